// File: rtl/gcn_pkg.sv
// Shared GCN datapath types: FSM state encoding,
// default widths and the product/accumulator row type.
package gcn_pkg;

  localparam int DEF_FEATURE_ROWS   = 6;
  localparam int DEF_WEIGHT_COLS    = 3;
  localparam int DEF_DOT_PROD_WIDTH = 16;
  localparam int DEF_COO_WIDTH      = 3;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  typedef logic [0:DEF_WEIGHT_COLS-1][DEF_DOT_PROD_WIDTH-1:0] row_t;

endpackage

// File: rtl/adj_acc_bank.sv
// Row register bank: sync clear, one row write port,
// two combinational row read ports (accumulate, emit).
module adj_acc_bank #(
  parameter int ROWS = 6,
  parameter int COLS = 3,
  parameter int DW   = 16,
  parameter int IW   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         wr_en,
  input  logic [IW-1:0]                wr_idx,
  input  logic [0:COLS-1][DW-1:0]      wr_row,
  input  logic [IW-1:0]                rd_a_idx,
  output logic [0:COLS-1][DW-1:0]      rd_a_row,
  input  logic [IW-1:0]                rd_b_idx,
  output logic [0:COLS-1][DW-1:0]      rd_b_row
);

  logic [0:COLS-1][DW-1:0] mem [0:ROWS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        mem[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < ROWS; i++)
        mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_row;
    end
  end

  assign rd_a_row = mem[rd_a_idx];
  assign rd_b_row = mem[rd_b_idx];

endmodule

// File: rtl/fm_wm_adj_accum.sv
// Edge aggregation: acc[dst] += fm_wm[src] per pair, then
// streams acc rows 0..N-1 out under valid/ready.
// Ports: start/edge_valid/src_row/dst_row/edge_ready/
// edges_done in; fm_wm_read_row/fm_wm_row_in to product
// memory (row data follows the registered address);
// out_valid/out_row_idx/out_row/out_ready, done, idx_err.
module fm_wm_adj_accum
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS   = DEF_FEATURE_ROWS,
  parameter int WEIGHT_COLS    = DEF_WEIGHT_COLS,
  parameter int DOT_PROD_WIDTH = DEF_DOT_PROD_WIDTH,
  parameter int COO_WIDTH      = DEF_COO_WIDTH,
  parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     edge_valid,
  input  logic [FEATURE_WIDTH-1:0] src_row,
  input  logic [COO_WIDTH-1:0]     dst_row,
  output logic                     edge_ready,
  input  logic                     edges_done,
  output logic [FEATURE_WIDTH-1:0] fm_wm_read_row,
  input  logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]
                                   fm_wm_row_in,
  output logic                     out_valid,
  output logic [FEATURE_WIDTH-1:0] out_row_idx,
  output logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0]
                                   out_row,
  input  logic                     out_ready,
  output logic                     done,
  output logic                     idx_err
);

  localparam logic [FEATURE_WIDTH-1:0] LAST =
    FEATURE_WIDTH'(FEATURE_ROWS - 1);

  typedef logic [0:WEIGHT_COLS-1][DOT_PROD_WIDTH-1:0] prow_t;

  state_t                   state, state_nxt;
  logic                     s1_valid;
  logic [FEATURE_WIDTH-1:0] s1_src;
  logic [FEATURE_WIDTH-1:0] s1_dst;
  logic [FEATURE_WIDTH-1:0] ptr;
  logic                     err_q;
  logic                     accept;
  logic                     bad;
  logic                     kick;
  prow_t                    acc_row;
  prow_t                    sum_row;
  prow_t                    emit_row;

  assign accept = edge_valid && edge_ready;
  assign bad    = (int'(src_row) >= FEATURE_ROWS)
               || (int'(dst_row) >= FEATURE_ROWS);
  assign kick   = start
               && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt  = state;
    edge_ready = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nxt = ACCUM;
      end
      ACCUM: begin
        edge_ready = 1'b1;
        // A pair accepted alongside edges_done is
        // processed first; leave on the next cycle.
        if (edges_done && !edge_valid)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!s1_valid) state_nxt = EMIT;
      end
      EMIT: begin
        out_valid = 1'b1;
        if (out_ready && (ptr == LAST))
          state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = ACCUM;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      s1_valid <= 1'b0;
      s1_src   <= '0;
      s1_dst   <= '0;
      ptr      <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      s1_valid <= accept && !bad;
      if (accept && !bad) begin
        s1_src <= FEATURE_WIDTH'(src_row);
        s1_dst <= FEATURE_WIDTH'(dst_row);
      end
      if (kick)
        err_q <= 1'b0;
      else if (accept && bad)
        err_q <= 1'b1;
      if (kick)
        ptr <= '0;
      else if ((state == EMIT) && out_ready)
        ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

  // Bank row is read after the previous write edge,
  // so same-dst pairs back to back chain correctly.
  always_comb begin
    sum_row = '0;
    for (int c = 0; c < WEIGHT_COLS; c++)
      sum_row[c] = acc_row[c] + fm_wm_row_in[c];
  end

  adj_acc_bank #(
    .ROWS (FEATURE_ROWS),
    .COLS (WEIGHT_COLS),
    .DW   (DOT_PROD_WIDTH),
    .IW   (FEATURE_WIDTH)
  ) u_bank (
    .clk      (clk),
    .rst_n    (reset),
    .clr      (kick),
    .wr_en    (s1_valid),
    .wr_idx   (s1_dst),
    .wr_row   (sum_row),
    .rd_a_idx (s1_dst),
    .rd_a_row (acc_row),
    .rd_b_idx (ptr),
    .rd_b_row (emit_row)
  );

  assign fm_wm_read_row = s1_src;
  assign out_row_idx    = ptr;
  assign out_row        = out_valid ? emit_row : '0;
  assign idx_err        = err_q;

endmodule
